// File: rtl/alu_mc_sequencer_pkg.sv
// alu_pkg: constants shared by ALU control, the ALU and the multi-cycle
// sequencer.
//   - alu_op_e    : 3-bit ALU control codes (7 is the illegal code)
//   - seq_state_e : sequencer state encoding
//   - DEFAULT_WIDTH : default datapath width
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'd0,
    ALU_XOR     = 3'd1,
    ALU_SLL     = 3'd2,
    ALU_SUB     = 3'd3,
    ALU_MUL     = 3'd4,
    ALU_SRA     = 3'd5,
    ALU_AND     = 3'd6,
    ALU_ILLEGAL = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_mc_sequencer_if.sv
// alu_mc_sequencer_if: request/response bundle between the decode stage
// (master) and the multi-cycle ALU sequencer (slave).
//   start_i, ALUCtrl_i, data1_i, data2_i, flush_i : request side (master drives)
//   ready_o, busy_o, done_o, result_o, illegal_o  : response side (slave drives)
interface alu_mc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             illegal_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  ready_o, busy_o, done_o, result_o, illegal_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output ready_o, busy_o, done_o, result_o, illegal_o
  );
endinterface

// File: rtl/alu_mc_sequencer_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiply datapath.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : capture operands, clear accumulator
//   step_i       : perform one iteration
//   last_i       : current step is the final one (accumulator is cleared)
//   data1_i      : multiplicand at load
//   data2_i      : multiplier at load
//   product_o    : accumulator plus this iteration's partial term
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] product_o
);
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] term;

  assign term      = mplier_reg[0] ? mcand_reg : '0;
  // Final value is taken combinationally so the result lands on the last edge.
  assign product_o = acc_reg + term;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (load_i) begin
      mcand_reg  <= data1_i;
      mplier_reg <= data2_i;
      acc_reg    <= '0;
    end else if (step_i) begin
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      acc_reg    <= last_i ? '0 : product_o;
    end
  end
endmodule

// File: rtl/alu_mc_sequencer.sv
// alu_mc_sequencer: multi-cycle ALU sequencer. Single-cycle ops complete on
// the accept edge; MUL takes WIDTH shift-add iterations.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : start/ready request, op code, operands, flush;
//                  busy (MUL in flight), done pulse, result, illegal flag
module alu_mc_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_mc_sequencer_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_e       state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_reg;
  logic             illegal_reg;

  logic             accept;
  logic             is_mul;
  logic             last_iter;
  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] product;
  logic [4:0]       shamt;
  alu_op_e          op;

  assign op        = alu_op_e'(bus.ALUCtrl_i);
  assign shamt     = bus.data2_i[4:0];
  assign is_mul    = (op == ALU_MUL);
  // A flush in IDLE drops a simultaneous request.
  assign accept    = bus.start_i && (state_reg == ST_IDLE) && !bus.flush_i;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
      ST_MUL:  if (bus.flush_i || last_iter) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    bus.ready_o = (state_reg == ST_IDLE);
    bus.busy_o  = (state_reg == ST_MUL);
    mul_load    = accept && is_mul;
    mul_step    = (state_reg == ST_MUL) && !bus.flush_i;
  end

  // Single-cycle op evaluation
  always_comb begin
    op_res = '0;
    case (op)
      ALU_ADD: op_res = bus.data1_i + bus.data2_i;
      ALU_SUB: op_res = bus.data1_i - bus.data2_i;
      ALU_XOR: op_res = bus.data1_i ^ bus.data2_i;
      ALU_AND: op_res = bus.data1_i & bus.data2_i;
      ALU_SLL: op_res = bus.data1_i << shamt;
      ALU_SRA: op_res = $signed(bus.data1_i) >>> shamt;
      default: op_res = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .last_i    (last_iter),
    .data1_i   (bus.data1_i),
    .data2_i   (bus.data2_i),
    .product_o (product)
  );

  // Iteration counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         cnt_reg <= '0;
    else if (mul_load) cnt_reg <= '0;
    else if (mul_step) cnt_reg <= cnt_reg + 1'b1;
  end

  // Registered completion outputs; a flush leaves result/illegal untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_reg  <= '0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept && !is_mul) begin
        result_reg  <= op_res;
        illegal_reg <= (op == ALU_ILLEGAL);
        done_reg    <= 1'b1;
      end else if (mul_step && last_iter) begin
        result_reg  <= product;
        illegal_reg <= 1'b0;
        done_reg    <= 1'b1;
      end
    end
  end

  assign bus.result_o  = result_reg;
  assign bus.done_o    = done_reg;
  assign bus.illegal_o = illegal_reg;
endmodule

// File: tb/tb_alu_mc_sequencer.sv
module tb_alu_mc_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_mc_sequencer_if #(.WIDTH(32)) bus ();

  alu_mc_sequencer #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Present a request for one edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Counts edges until done_o is seen (bounded) and busy cycles on the way.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = -1;
    busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done_o) begin
        edges = n;
        break;
      end
      if (bus.busy_o) busy_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int edges;
  int busy_cnt;
  int done_seen;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 3'd0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.flush_i   = 1'b0;
    step_edges(2);
    check_val("rst ready", 32'(bus.ready_o), 32'd1);
    check_val("rst busy", 32'(bus.busy_o), 32'd0);
    check_val("rst done", 32'(bus.done_o), 32'd0);
    check_val("rst result", bus.result_o, 32'd0);
    check_val("rst illegal", 32'(bus.illegal_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'd5, 32'd7);
    check_val("add done", 32'(bus.done_o), 32'd1);
    check_val("add result", bus.result_o, 32'd12);
    check_val("add ready", 32'(bus.ready_o), 32'd1);
    step_edges(1);
    check_val("add done pulse", 32'(bus.done_o), 32'd0);

    issue(3'd3, 32'd3, 32'd5);
    check_val("sub result", bus.result_o, 32'hFFFF_FFFE);
    issue(3'd5, 32'h8000_0000, 32'd4);
    check_val("sra result", bus.result_o, 32'hF800_0000);
    issue(3'd2, 32'd1, 32'd31);
    check_val("sll result", bus.result_o, 32'h8000_0000);
    step_edges(1);

    // Back-to-back XOR then AND on consecutive edges
    issue(3'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check_val("xor done", 32'(bus.done_o), 32'd1);
    check_val("xor result", bus.result_o, 32'hFF00_0FF0);
    issue(3'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check_val("and done", 32'(bus.done_o), 32'd1);
    check_val("and result", bus.result_o, 32'h00F0_000F);
    step_edges(1);

    // MUL with start held high throughout (must be ignored)
    issue(3'd4, 32'hFFFF_FFFF, 32'd3);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = 3'd0;
    bus.data1_i   = 32'd1;
    bus.data2_i   = 32'd1;
    check_val("mul busy", 32'(bus.busy_o), 32'd1);
    wait_done(edges, busy_cnt);
    bus.start_i = 1'b0;
    check_val("mul latency", 32'(edges), 32'd32);
    check_val("mul busy cycles", 32'(busy_cnt), 32'd32);
    check_val("mul result", bus.result_o, 32'hFFFF_FFFD);
    check_val("mul ready at done", 32'(bus.ready_o), 32'd1);
    step_edges(1);
    check_val("mul done single", 32'(bus.done_o), 32'd0);

    // Flush on iteration 10 (edge k+10)
    issue(3'd4, 32'd5, 32'd5);
    step_edges(9);
    bus.flush_i = 1'b1;
    step_edges(1);
    bus.flush_i = 1'b0;
    check_val("flush10 ready", 32'(bus.ready_o), 32'd1);
    check_val("flush10 done", 32'(bus.done_o), 32'd0);
    check_val("flush10 result", bus.result_o, 32'hFFFF_FFFD);
    done_seen = 0;
    for (int i = 0; i < 35; i++) begin
      step_edges(1);
      if (bus.done_o) done_seen++;
    end
    check_val("flush10 no late done", 32'(done_seen), 32'd0);

    // Flush on the final iteration edge (k+32)
    issue(3'd4, 32'd5, 32'd5);
    step_edges(31);
    bus.flush_i = 1'b1;
    step_edges(1);
    bus.flush_i = 1'b0;
    check_val("flushlast done", 32'(bus.done_o), 32'd0);
    check_val("flushlast result", bus.result_o, 32'hFFFF_FFFD);
    check_val("flushlast ready", 32'(bus.ready_o), 32'd1);

    // Flush together with start in IDLE drops the request
    bus.flush_i = 1'b1;
    issue(3'd0, 32'd2, 32'd2);
    bus.flush_i = 1'b0;
    check_val("flush idle done", 32'(bus.done_o), 32'd0);
    check_val("flush idle result", bus.result_o, 32'hFFFF_FFFD);

    // Illegal op then ADD clears the flag
    issue(3'd7, 32'd1, 32'd2);
    check_val("ill done", 32'(bus.done_o), 32'd1);
    check_val("ill result", bus.result_o, 32'd0);
    check_val("ill flag", 32'(bus.illegal_o), 32'd1);
    issue(3'd0, 32'd1, 32'd1);
    check_val("ill clear", 32'(bus.illegal_o), 32'd0);
    check_val("ill add result", bus.result_o, 32'd2);

    // Asynchronous reset mid-MUL
    issue(3'd4, 32'd3, 32'd3);
    step_edges(5);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst ready", 32'(bus.ready_o), 32'd1);
    check_val("arst busy", 32'(bus.busy_o), 32'd0);
    check_val("arst result", bus.result_o, 32'd0);
    check_val("arst done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd4, 32'd6, 32'd7);
    wait_done(edges, busy_cnt);
    check_val("mul2 latency", 32'(edges), 32'd32);
    check_val("mul2 result", bus.result_o, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
